// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/instr_hold_reg.sv
// Output holding register for the fetched instruction and its PC.
// Loads on load_i, otherwise holds; async active-low clear to zero.
module instr_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic [2*WIDTH-1:0] data_q;
  logic [2*WIDTH-1:0] data_d;

  assign data_d = load_i ? {instr_i, pc_i} : data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign instr_o = data_q[2*WIDTH-1:WIDTH];
  assign pc_o    = data_q[WIDTH-1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch stage with redirect/flush handling.
// Optional FETCH_PERF_EN adds fetch and flush event counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  fetch_state_t     state_q;
  logic [WIDTH-1:0] pc_q;
  logic             drop_q;
  logic             req_q;
  logic             valid_q;

  logic             granted;
  logic             resp_take;
  logic             load_en;
  logic             flush_evt;
  logic [WIDTH-1:0] pc_seq;

  assign granted   = (state_q == S_REQ) && req_q && imem_gnt;
  assign resp_take = (state_q == S_WAIT) && imem_rvalid;
  assign load_en   = resp_take && !drop_q && !redirect;
  assign flush_evt = resp_take && (drop_q || redirect);
  assign pc_seq    = pc_q + WIDTH'(PC_INCR);

  // req_q mirrors "in S_REQ" except for the first cycle out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (redirect) begin
        pc_q <= pc_next;
      end
      case (state_q)
        S_REQ: begin
          if (granted) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
            drop_q  <= redirect;
          end else begin
            req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (flush_evt) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            drop_q  <= 1'b0;
          end else if (load_en) begin
            state_q <= S_HOLD;
            valid_q <= 1'b1;
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || instr_ready) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            if (!redirect) begin
              pc_q <= pc_seq;
            end
          end
        end
        default: begin
          state_q <= S_REQ;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          drop_q  <= 1'b0;
        end
      endcase
    end
  end

  instr_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (load_en),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .instr_o (instr),
    .pc_o    (instr_pc)
  );

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (valid_q && instr_ready) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (flush_evt) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
